// File: rtl/uart_pkg.sv
// Shared UART constants: receive word layout and receive FIFO geometry.
package uart_pkg;

    localparam int RX_DATA_WIDTH      = 9;
    localparam int RX_FIFO_DEPTH      = 16;
    localparam int RX_FIFO_ADDR_WIDTH = 4;

    localparam int RX_PARITY_BIT = 8;
    localparam int RX_DATA_MSB   = 7;

endpackage

// File: rtl/rx_fifo_mem.sv
// Unreset register array with one synchronous write port and one asynchronous read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_word
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_word = mem[rd_addr];

endmodule

// File: rtl/rx_fifo.sv
// UART receive FIFO: edge-triggered push from the receiver, first-word-fall-through pop, status flags.
module rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH,
    parameter int DEPTH      = RX_FIFO_DEPTH,
    parameter int ADDR_WIDTH = RX_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_request,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_request,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic [ADDR_WIDTH-1:0] threshold,
    output logic                  watermark,
    output logic                  overflow,
    input  logic                  clearOV,
    input  logic                  flush
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [ADDR_WIDTH:0]   count_nx;
    logic [DATA_WIDTH-1:0] mem_word, head_nx;
    logic                  wr_req_d, push, pop, push_ok, ov_set, mem_we;

    assign empty     = (count == '0);
    assign full      = (count == CNT_FULL);
    assign watermark = (count > {1'b0, threshold});

    always_comb begin
        push      = wr_request & ~wr_req_d;
        pop       = rd_request & ~empty;
        push_ok   = push & (~full | pop);
        ov_set    = push & full & ~pop & ~flush;
        mem_we    = push_ok & ~flush;
        wr_ptr_nx = wr_ptr;
        rd_ptr_nx = rd_ptr;
        count_nx  = count;
        if (flush) begin
            wr_ptr_nx = '0;
            rd_ptr_nx = '0;
            count_nx  = '0;
        end else begin
            if (push_ok) wr_ptr_nx = wr_ptr + PTR_ONE;
            if (pop)     rd_ptr_nx = rd_ptr + PTR_ONE;
            if (push_ok && !pop)      count_nx = count + CNT_ONE;
            else if (pop && !push_ok) count_nx = count - CNT_ONE;
        end
        // A word written this cycle into the new head slot is not in memory yet, so bypass it.
        head_nx = (mem_we && (rd_ptr_nx == wr_ptr)) ? wr_data : mem_word;
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (mem_we),
        .wr_addr(wr_ptr),
        .wr_data(wr_data),
        .rd_addr(rd_ptr_nx),
        .rd_word(mem_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_req_d <= 1'b0;
            overflow <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nx;
            rd_ptr   <= rd_ptr_nx;
            count    <= count_nx;
            wr_req_d <= wr_request;
            if (ov_set)       overflow <= 1'b1;
            else if (clearOV) overflow <= 1'b0;
            if (count_nx != '0) rd_data <= head_nx;
        end
    end

endmodule

// File: tb/tb_rx_fifo.sv
// Scoreboard bench for rx_fifo: stimulus queues expected words, a monitor checks every pop.
module tb_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_request = 1'b0;
    logic [8:0] wr_data = '0;
    logic       rd_request = 1'b0;
    logic [8:0] rd_data;
    logic       full, empty, watermark, overflow;
    logic [4:0] count;
    logic [3:0] threshold = 4'd15;
    logic       clearOV = 1'b0;
    logic       flush = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;
    logic [8:0] expQ[$];

    rx_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .wr_request(wr_request),
        .wr_data   (wr_data),
        .rd_request(rd_request),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .threshold (threshold),
        .watermark (watermark),
        .overflow  (overflow),
        .clearOV   (clearOV),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Every accepted pop must return the oldest word still owed by the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && rd_request === 1'b1 && empty === 1'b0) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL pop_unexpected: got %0h, expected no word", rd_data);
                end else begin
                    compare("pop_data", 32'(rd_data), 32'(expQ.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int expCount, input logic expOv);
        compare({name, "_count"}, 32'(count), 32'(expCount));
        compare({name, "_empty"}, 32'(empty), 32'(expCount == 0));
        compare({name, "_full"}, 32'(full), 32'(expCount == 16));
        compare({name, "_overflow"}, 32'(overflow), 32'(expOv));
        compare({name, "_watermark"}, 32'(watermark), 32'(expCount > int'(threshold)));
    endtask

    // One active cycle with the given inputs, then one idle cycle so wr_request can re-arm.
    task automatic applyStimulus(input logic wr, input logic [8:0] d, input logic rd,
                                 input logic clr, input logic fl, input logic expectPush);
        if (expectPush) expQ.push_back(d);
        wr_request = wr;
        wr_data    = d;
        rd_request = rd;
        clearOV    = clr;
        flush      = fl;
        tick();
        wr_request = 1'b0;
        rd_request = 1'b0;
        clearOV    = 1'b0;
        flush      = 1'b0;
        tick();
    endtask

    task automatic pushWord(input logic [8:0] d, input logic expectPush);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, expectPush);
    endtask

    task automatic popWord();
        applyStimulus(1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        checkOutput("reset", 0, 1'b0);
        compare("reset_rd_data", 32'(rd_data), 32'h0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;

        // Held write request gives a single push, visible one clock after the edge.
        wr_request = 1'b1;
        wr_data    = 9'h155;
        expQ.push_back(9'h155);
        tick();
        checkOutput("hold_first", 1, 1'b0);
        compare("hold_rd_data", 32'(rd_data), 32'h155);
        repeat (19) tick();
        checkOutput("hold_end", 1, 1'b0);
        wr_request = 1'b0;
        tick();
        popWord();
        checkOutput("hold_drained", 0, 1'b0);

        // Fill and drain through the pointer wrap.
        for (int i = 0; i < 16; i++) pushWord(9'(i), 1'b1);
        checkOutput("fill16", 16, 1'b0);
        for (int i = 0; i < 16; i++) popWord();
        checkOutput("drain16", 0, 1'b0);

        // Overflow set, clear, and set-wins-over-clear.
        for (int i = 0; i < 16; i++) pushWord(9'h040 + 9'(i), 1'b1);
        pushWord(9'h1AA, 1'b0);
        checkOutput("overflow_set", 16, 1'b1);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("overflow_clear", 16, 1'b0);
        applyStimulus(1'b1, 9'h1AB, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("overflow_set_wins", 16, 1'b1);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Push with pop while full.
        applyStimulus(1'b1, 9'h0FF, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("full_push_pop", 16, 1'b0);
        for (int i = 0; i < 16; i++) popWord();
        checkOutput("full_push_pop_drain", 0, 1'b0);

        // Push with pop while empty: the pop is ignored.
        applyStimulus(1'b1, 9'h033, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("empty_push_pop", 1, 1'b0);
        compare("empty_push_pop_rd_data", 32'(rd_data), 32'h033);
        popWord();
        checkOutput("empty_push_pop_drain", 0, 1'b0);
        popWord();
        checkOutput("pop_while_empty", 0, 1'b0);

        // Watermark strictly above threshold.
        threshold = 4'd4;
        for (int i = 0; i < 5; i++) begin
            pushWord(9'h010 + 9'(i), 1'b1);
            checkOutput($sformatf("wm_%0d", i + 1), i + 1, 1'b0);
        end
        compare("wm_at5", 32'(watermark), 32'h1);

        // Flush beats a coincident push; held request must not re-push.
        wr_request = 1'b1;
        wr_data    = 9'h077;
        flush      = 1'b1;
        tick();
        flush = 1'b0;
        expQ.delete();
        repeat (3) tick();
        wr_request = 1'b0;
        tick();
        checkOutput("flush", 0, 1'b0);

        // Asynchronous reset mid-stream.
        pushWord(9'h101, 1'b1);
        pushWord(9'h102, 1'b1);
        checkOutput("pre_reset", 2, 1'b0);
        #2 reset = 1'b0;
        #1;
        expQ.delete();
        checkOutput("async_reset", 0, 1'b0);
        compare("async_reset_rd_data", 32'(rd_data), 32'h0);
        #2 reset = 1'b1;
        tick();
        checkOutput("after_reset", 0, 1'b0);
        compare("queue_empty_at_end", 32'(expQ.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
